// File: rtl/plic_arbiter.sv
// PLIC interrupt core: per-source gateways with pending/claimed tracking, priority
// arbitration with a registered winner, external interrupt request and claim/complete service.
module plic_arbiter #(
  parameter int IRQ_NUM    = 21,
  parameter int PRIO_WIDTH = 4,
  parameter int ID_WIDTH   = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [IRQ_NUM-1:0]           irq_i,
  input  logic [IRQ_NUM-1:0]           edge_i,
  input  logic [IRQ_NUM-1:0]           ie_i,
  input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]        thold_i,
  input  logic                         claim_i,
  output logic [ID_WIDTH-1:0]          claim_id_o,
  input  logic                         complete_i,
  input  logic [ID_WIDTH-1:0]          complete_id_i,
  output logic [IRQ_NUM-1:0]           ip_o,
  output logic                         ext_irq_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_CLAIMED = 2'd2
  } src_state_e;

  // Source 0 is reserved: masking it here keeps it permanently idle.
  localparam logic [IRQ_NUM-1:0] SRC_MASK = ~IRQ_NUM'(1);

  src_state_e state_q [IRQ_NUM];
  src_state_e state_d [IRQ_NUM];
  logic [IRQ_NUM-1:0] missed_q, missed_d;
  logic [IRQ_NUM-1:0] irq_q;

  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] edge_hit;
  logic [IRQ_NUM-1:0] trig;
  logic [IRQ_NUM-1:0] eligible;

  logic [ID_WIDTH-1:0]   best_id;
  logic [PRIO_WIDTH-1:0] best_prio;
  logic [ID_WIDTH-1:0]   win_id;
  logic [PRIO_WIDTH-1:0] win_prio;

  assign rise     = irq_i & ~irq_q & SRC_MASK;
  assign edge_hit = rise & edge_i;
  assign trig     = edge_hit | (irq_i & ~edge_i & SRC_MASK);
  assign eligible = ip_o & ie_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races between blocks.
  // NOTE: the per-source state array is small control state, so it is reset like
  // any flop; it is not a RAM and must come up IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < IRQ_NUM; n++) state_q[n] <= S_IDLE;
      missed_q <= '0;
      irq_q    <= '0;
    end else begin
      for (int n = 0; n < IRQ_NUM; n++) state_q[n] <= state_d[n];
      missed_q <= missed_d;
      irq_q    <= irq_i;
    end
  end

  // NOTE: every output of a combinational block is given a default first so no
  // path through the case/if tree leaves a variable unassigned (which infers a latch).
  always_comb begin
    missed_d = missed_q;
    for (int n = 0; n < IRQ_NUM; n++) begin
      state_d[n] = state_q[n];
      unique case (state_q[n])
        S_IDLE: begin
          if (trig[n]) state_d[n] = S_PENDING;
        end
        S_PENDING: begin
          if (claim_id_o == ID_WIDTH'(n)) state_d[n] = S_CLAIMED;
          if (edge_hit[n]) missed_d[n] = 1'b1;
        end
        S_CLAIMED: begin
          if (complete_i && complete_id_i == ID_WIDTH'(n)) begin
            // A remembered (or simultaneous) edge re-pends straight away.
            state_d[n]  = (missed_q[n] || edge_hit[n]) ? S_PENDING : S_IDLE;
            missed_d[n] = 1'b0;
          end else if (edge_hit[n]) begin
            missed_d[n] = 1'b1;
          end
        end
        default: state_d[n] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ip_o = '0;
    for (int n = 0; n < IRQ_NUM; n++) ip_o[n] = (state_q[n] == S_PENDING);
    claim_id_o = (claim_i && win_prio > thold_i) ? win_id : '0;
  end

  // Strict greater-than while scanning upward makes ties resolve to the lowest ID;
  // starting from prio 0 excludes zero-priority sources.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int n = 0; n < IRQ_NUM; n++) begin
      if (eligible[n] && prio_i[n*PRIO_WIDTH +: PRIO_WIDTH] > best_prio) begin
        best_id   = ID_WIDTH'(n);
        best_prio = prio_i[n*PRIO_WIDTH +: PRIO_WIDTH];
      end
    end
  end

  // The cycle after a claim is a bubble: the claimed source's pending bit is only
  // now clearing, so the stale winner must not be offered again.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_id    <= '0;
      win_prio  <= '0;
      ext_irq_o <= 1'b0;
    end else if (claim_i) begin
      win_id    <= '0;
      win_prio  <= '0;
      ext_irq_o <= 1'b0;
    end else begin
      win_id    <= best_id;
      win_prio  <= best_prio;
      ext_irq_o <= (best_prio > thold_i);
    end
  end

endmodule
